// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared op/state encodings for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_LSH  = 3'd2,
        OP_ASH  = 3'd3,
        OP_ROT  = 3'd4,
        OP_ROTC = 3'd5,
        OP_ILL6 = 3'd6,
        OP_ILL7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_LSH) || (op == OP_ASH) || (op == OP_ROT) || (op == OP_ROTC);
    endfunction

    function automatic logic is_illegal_op(input op_e op);
        return (op == OP_ILL6) || (op == OP_ILL7);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - command handshake bundle for the shift sequencer
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] load_data;
    logic             carry_in;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_count, load_data, carry_in,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_count, load_data, carry_in,
        output cmd_ready
    );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shift/rotate datapath
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIN_W = 1
) (
    input  op_e              op,
    input  logic             dir,
    input  logic [WIDTH-1:0] cur,
    input  logic             carry,
    input  logic [SIN_W-1:0] sin,
    output logic [WIDTH-1:0] nxt,
    output logic             nxt_carry
);
    localparam int RW = WIDTH + 1;

    logic [RW-1:0] ring;
    logic [RW-1:0] ring_l;
    logic [RW-1:0] ring_r;
    logic          edge_bit;

    always_comb begin
        ring     = {carry, cur};
        ring_l   = (ring << SIN_W) | (ring >> (RW - SIN_W));
        ring_r   = (ring >> SIN_W) | (ring << (RW - SIN_W));
        // last bit to leave the register on the side it exits
        edge_bit = (dir == DIR_LEFT) ? cur[WIDTH-SIN_W] : cur[SIN_W-1];

        nxt       = cur;
        nxt_carry = carry;
        case (op)
            OP_LSH: begin
                nxt       = (dir == DIR_LEFT) ? {cur[WIDTH-SIN_W-1:0], sin}
                                              : {sin, cur[WIDTH-1:SIN_W]};
                nxt_carry = edge_bit;
            end
            OP_ASH: begin
                nxt       = (dir == DIR_LEFT) ? {cur[WIDTH-SIN_W-1:0], {SIN_W{1'b0}}}
                                              : {{SIN_W{cur[WIDTH-1]}}, cur[WIDTH-1:SIN_W]};
                nxt_carry = edge_bit;
            end
            OP_ROT: begin
                nxt       = (dir == DIR_LEFT) ? {cur[WIDTH-SIN_W-1:0], cur[WIDTH-1:WIDTH-SIN_W]}
                                              : {cur[SIN_W-1:0], cur[WIDTH-1:SIN_W]};
                nxt_carry = edge_bit;
            end
            OP_ROTC: begin
                {nxt_carry, nxt} = (dir == DIR_LEFT) ? ring_l : ring_r;
            end
            default: begin
                nxt       = cur;
                nxt_carry = carry;
            end
        endcase
    end
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step shift engine: FSM, step counter, registers
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SIN_W = 1,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  cmd,
    input  logic [SIN_W-1:0]  sin,
    input  logic              abort,
    output logic [WIDTH-1:0]  out,
    output logic              carry_out,
    output logic              sin_rd,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_e           state, state_nxt;
    op_e              op_r;
    logic             dir_r;
    logic [CNT_W-1:0] rem;
    logic             err_r;
    op_e              cmd_op_e;
    logic             start_run;
    logic [WIDTH-1:0] step_out;
    logic             step_carry;

    assign cmd_op_e  = op_e'(cmd.cmd_op);
    assign start_run = is_shift_op(cmd_op_e) && (cmd.cmd_count != '0);

    shift_step #(.WIDTH(WIDTH), .SIN_W(SIN_W)) u_step (
        .op        (op_r),
        .dir       (dir_r),
        .cur       (out),
        .carry     (carry_out),
        .sin       (sin),
        .nxt       (step_out),
        .nxt_carry (step_carry)
    );

    always_comb begin
        state_nxt     = state;
        cmd.cmd_ready = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        err           = 1'b0;
        sin_rd        = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (cmd.cmd_valid) begin
                    state_nxt = start_run ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                sin_rd = (op_r == OP_LSH);
                if (abort || (rem == CNT_W'(1))) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                err       = err_r;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            out       <= '0;
            carry_out <= 1'b0;
            op_r      <= OP_NOP;
            dir_r     <= DIR_RIGHT;
            rem       <= '0;
            err_r     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r  <= cmd_op_e;
                        dir_r <= cmd.cmd_dir;
                        rem   <= cmd.cmd_count;
                        err_r <= is_illegal_op(cmd_op_e);
                        if (cmd_op_e == OP_LOAD) begin
                            out <= cmd.load_data;
                        end
                        // zero-step shifts leave carry untouched, like NOP
                        if (start_run) begin
                            carry_out <= cmd.carry_in;
                        end
                    end
                end
                ST_RUN: begin
                    if (!abort) begin
                        out       <= step_out;
                        carry_out <= step_carry;
                        rem       <= rem - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - vector table, corner sequences and randomized model check
module tb_shift_sequencer;
    localparam int W = 8;
    localparam int S = 1;
    localparam int C = 4;

    logic         clk;
    logic         rst;
    logic [S-1:0] sin;
    logic         abort;
    logic [W-1:0] out;
    logic         carry_out, sin_rd, busy, done, err;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] m_out;
    logic         m_carry;

    shift_sequencer_if #(.WIDTH(W), .CNT_W(C)) cmd_if ();

    shift_sequencer #(.WIDTH(W), .SIN_W(S), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .sin       (sin),
        .abort     (abort),
        .out       (out),
        .carry_out (carry_out),
        .sin_rd    (sin_rd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic        dir;
        logic [3:0]  cnt;
        logic [7:0]  data;
        logic        cin;
        logic [15:0] sinv;
        int          abort_at;
        logic [7:0]  e_out;
        logic        e_carry;
        logic        e_err;
        int          e_lat;
        int          e_sinrd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each register bit is fetched from where the rules say it comes from.
    function automatic void model_step(input int op, input logic dir, input logic s,
                                       inout logic [7:0] r, inout logic c);
        logic [7:0] o;
        logic [8:0] ring, nring;
        o = r;
        if (op == 5) begin
            ring = {c, o};
            for (int i = 0; i < W + 1; i++)
                nring[i] = dir ? ring[(i - S + W + 1) % (W + 1)] : ring[(i + S) % (W + 1)];
            c = nring[W];
            r = nring[W-1:0];
        end else if (op >= 2 && op <= 4) begin
            for (int i = 0; i < W; i++) begin
                if (dir) begin
                    if (i >= S) r[i] = o[i-S];
                    else r[i] = (op == 2) ? s : (op == 3) ? 1'b0 : o[W-S+i];
                end else begin
                    if (i < W - S) r[i] = o[i+S];
                    else r[i] = (op == 2) ? s : (op == 3) ? o[W-1] : o[i-(W-S)];
                end
            end
            c = dir ? o[W-S] : o[S-1];
        end
    endfunction

    function automatic void model_cmd(input int op, input logic dir, input int cnt,
                                      input logic [7:0] data, input logic cin,
                                      input logic [15:0] sinv, input int abort_at,
                                      inout logic [7:0] r, inout logic c,
                                      output logic e, output int lat, output int sinrd);
        int steps;
        e = (op >= 6);
        lat = 1;
        sinrd = 0;
        if (op == 1) begin
            r = data;
        end else if (op >= 2 && op <= 5 && cnt != 0) begin
            c = cin;
            if (abort_at >= 1 && abort_at <= cnt) begin
                steps = abort_at - 1;
                lat = abort_at + 1;
            end else begin
                steps = cnt;
                lat = cnt + 1;
            end
            if (op == 2) sinrd = cnt;
            for (int k = 0; k < steps; k++)
                model_step(op, dir, sinv[k], r, c);
        end
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic dir, input logic [3:0] cnt,
                          input logic [7:0] data, input logic cin, input logic [15:0] sinv,
                          input int abort_at, input bit junk,
                          output logic [7:0] o_out, output logic o_carry, output logic o_err,
                          output int o_lat, output int o_sinrd);
        bit seen;
        seen = 0;
        o_lat = -1;
        o_sinrd = 0;
        o_out = '0;
        o_carry = 1'b0;
        o_err = 1'b0;
        chk("cmd_ready_idle", {31'b0, cmd_if.cmd_ready}, 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_dir   = dir;
        cmd_if.cmd_count = cnt;
        cmd_if.load_data = data;
        cmd_if.carry_in  = cin;
        sin = '0;
        abort = 1'b0;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            if (done) begin
                seen = 1;
                o_lat = cyc;
                o_out = out;
                o_carry = carry_out;
                o_err = err;
            end else begin
                if (sin_rd) o_sinrd++;
                sin = (cyc <= 16) ? sinv[cyc-1] : 1'b0;
                abort = (cyc == abort_at);
                if (junk) begin
                    cmd_if.cmd_valid = 1'($urandom_range(0, 1));
                    cmd_if.cmd_op    = 3'($urandom);
                    cmd_if.cmd_count = 4'($urandom);
                    cmd_if.load_data = 8'($urandom);
                end
                @(posedge clk); #1;
            end
        end
        cmd_if.cmd_valid = 1'b0;
        abort = 1'b0;
        sin = '0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within 40 cycles, op %0d count %0d", op, cnt);
        end else begin
            @(posedge clk); #1;
            chk("done_one_cycle", {31'b0, done}, 32'd0);
            chk("ready_after_done", {31'b0, cmd_if.cmd_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] o_out;
        logic       o_carry, o_err, e_err;
        int         o_lat, o_sinrd, e_lat, e_sinrd, dones;
        logic [2:0] op;
        logic [3:0] cnt;
        int         abort_at;
        logic       dir, cin;
        logic [7:0] data;
        logic [15:0] sinv;

        rst = 1'b1;
        sin = '0;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = '0;
        cmd_if.cmd_dir = 1'b0;
        cmd_if.cmd_count = '0;
        cmd_if.load_data = '0;
        cmd_if.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", {24'b0, out}, 32'h0);
        chk("rst_carry", {31'b0, carry_out}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'b0, cmd_if.cmd_ready}, 32'd1);

        // reset in the middle of a running LSH abandons it without done
        do_cmd(3'd1, 1'b0, 4'd0, 8'hFF, 1'b0, 16'h0, 0, 0, o_out, o_carry, o_err, o_lat, o_sinrd);
        chk("pre_load_out", {24'b0, o_out}, 32'hFF);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op = 3'd2;
        cmd_if.cmd_dir = 1'b1;
        cmd_if.cmd_count = 4'd5;
        sin = 1'b0;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_run_out", {24'b0, out}, 32'hFC);
        chk("mid_run_busy", {31'b0, busy}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out", {24'b0, out}, 32'h0);
        chk("async_rst_carry", {31'b0, carry_out}, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        @(posedge clk); #1;
        chk("ready_after_mid_rst", {31'b0, cmd_if.cmd_ready}, 32'd1);
        repeat (6) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        chk("no_done_after_rst", dones, 32'd0);

        //            op   dir   cnt    data   cin   sinv      ab  out    c     e     lat sinrd
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'hA5, 1'b0, 16'h0000, 0, 8'hA5, 1'b0, 1'b0, 1,  0});
        vecs.push_back('{3'd0, 1'b0, 4'd3,  8'h00, 1'b1, 16'h0000, 0, 8'hA5, 1'b0, 1'b0, 1,  0});
        vecs.push_back('{3'd4, 1'b1, 4'd0,  8'h00, 1'b1, 16'h0000, 0, 8'hA5, 1'b0, 1'b0, 1,  0});
        vecs.push_back('{3'd2, 1'b1, 4'd3,  8'h00, 1'b0, 16'h0005, 0, 8'h2D, 1'b1, 1'b0, 4,  3});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h90, 1'b0, 16'h0000, 0, 8'h90, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3'd3, 1'b0, 4'd2,  8'h00, 1'b1, 16'h0000, 0, 8'hE4, 1'b0, 1'b0, 3,  0});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h81, 1'b0, 16'h0000, 0, 8'h81, 1'b0, 1'b0, 1,  0});
        vecs.push_back('{3'd3, 1'b1, 4'd1,  8'h00, 1'b0, 16'h0000, 0, 8'h02, 1'b1, 1'b0, 2,  0});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h80, 1'b0, 16'h0000, 0, 8'h80, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3'd5, 1'b1, 4'd1,  8'h00, 1'b0, 16'h0000, 0, 8'h00, 1'b1, 1'b0, 2,  0});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h80, 1'b0, 16'h0000, 0, 8'h80, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3'd5, 1'b1, 4'd9,  8'h00, 1'b0, 16'h0000, 0, 8'h80, 1'b0, 1'b0, 10, 0});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h01, 1'b0, 16'h0000, 0, 8'h01, 1'b0, 1'b0, 1,  0});
        vecs.push_back('{3'd4, 1'b0, 4'd1,  8'h00, 1'b0, 16'h0000, 0, 8'h80, 1'b1, 1'b0, 2,  0});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h01, 1'b0, 16'h0000, 0, 8'h01, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3'd5, 1'b0, 4'd1,  8'h00, 1'b0, 16'h0000, 0, 8'h00, 1'b1, 1'b0, 2,  0});
        vecs.push_back('{3'd1, 1'b0, 4'd0,  8'h0F, 1'b0, 16'h0000, 0, 8'h0F, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3'd2, 1'b0, 4'd5,  8'h00, 1'b0, 16'hFFFF, 3, 8'hC3, 1'b1, 1'b0, 4, -1});
        vecs.push_back('{3'd6, 1'b1, 4'd2,  8'h00, 1'b0, 16'h0000, 0, 8'hC3, 1'b1, 1'b1, 1,  0});
        vecs.push_back('{3'd7, 1'b0, 4'd0,  8'h00, 1'b0, 16'h0000, 0, 8'hC3, 1'b1, 1'b1, 1,  0});
        vecs.push_back('{3'd5, 1'b1, 4'd0,  8'h00, 1'b0, 16'h0000, 0, 8'hC3, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3'd2, 1'b1, 4'd15, 8'h00, 1'b0, 16'h0000, 0, 8'h00, 1'b0, 1'b0, 16, 15});
        vecs.push_back('{3'd3, 1'b0, 4'd4,  8'h00, 1'b1, 16'h0000, 1, 8'h00, 1'b1, 1'b0, 2, -1});

        foreach (vecs[i]) begin
            do_cmd(vecs[i].op, vecs[i].dir, vecs[i].cnt, vecs[i].data, vecs[i].cin,
                   vecs[i].sinv, vecs[i].abort_at, 0, o_out, o_carry, o_err, o_lat, o_sinrd);
            chk($sformatf("v%0d_out", i), {24'b0, o_out}, {24'b0, vecs[i].e_out});
            chk($sformatf("v%0d_carry", i), {31'b0, o_carry}, {31'b0, vecs[i].e_carry});
            chk($sformatf("v%0d_err", i), {31'b0, o_err}, {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d_lat", i), o_lat, vecs[i].e_lat);
            if (vecs[i].e_sinrd >= 0)
                chk($sformatf("v%0d_sinrd", i), o_sinrd, vecs[i].e_sinrd);
        end
        m_out = 8'h00;
        m_carry = 1'b1;

        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                abort = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            abort = 1'b0;
            op = 3'($urandom_range(0, 7));
            dir = 1'($urandom_range(0, 1));
            cnt = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            data = 8'($urandom);
            cin = 1'($urandom_range(0, 1));
            sinv = 16'($urandom);
            abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(cnt) + 1) : 0;
            model_cmd(int'(op), dir, int'(cnt), data, cin, sinv, abort_at,
                      m_out, m_carry, e_err, e_lat, e_sinrd);
            do_cmd(op, dir, cnt, data, cin, sinv, abort_at, 1, o_out, o_carry, o_err, o_lat, o_sinrd);
            chk($sformatf("r%0d_out", n), {24'b0, o_out}, {24'b0, m_out});
            chk($sformatf("r%0d_carry", n), {31'b0, o_carry}, {31'b0, m_carry});
            chk($sformatf("r%0d_err", n), {31'b0, o_err}, {31'b0, e_err});
            chk($sformatf("r%0d_lat", n), o_lat, e_lat);
            if (abort_at == 0 || abort_at > int'(cnt))
                chk($sformatf("r%0d_sinrd", n), o_sinrd, e_sinrd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
